// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit and its datapath.
// Also holds the per-state control word table used by the FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } statetype_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic       irwrite;
        logic       pcupdate;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore control word for each state; anything not set stays 0.
    function automatic ctrl_t state_ctrl(statetype_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
                c.irwrite   = 1'b1;
                c.pcupdate  = 1'b1;
            end
            S_DECODE: begin
                c.alusrca = SRCA_OLDPC;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTER: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_WD;
                c.aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB:    c.regwrite = 1'b1;
            S_BRANCH: begin
                c.alusrca = SRCA_A;
                c.alusrcb = SRCB_WD;
                c.aluop   = ALUOP_SUB;
                c.branch  = 1'b1;
            end
            S_JAL: begin
                c.alusrca  = SRCA_OLDPC;
                c.alusrcb  = SRCB_FOUR;
                c.pcupdate = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_src(logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps the FSM's ALUOp plus instruction fields to ALUControl.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from addi, whose imm may set bit 30
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM: registered Moore control word per state,
// plus ImmSrc/ALUControl decode and the branch-qualified PCWrite.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);

    statetype_t state;
    ctrl_t      ctrl;
    ctrl_t      cur;
    logic       taken;

    function automatic statetype_t next_state(statetype_t s, logic [6:0] o);
        statetype_t ns;
        ns = S_FETCH;
        case (s)
            S_FETCH:  ns = S_DECODE;
            S_DECODE: begin
                case (o)
                    OP_LW, OP_SW: ns = S_MEMADR;
                    OP_RTYPE:     ns = S_EXECUTER;
                    OP_IALU:      ns = S_EXECUTEI;
                    OP_BRANCH:    ns = S_BRANCH;
                    OP_JAL:       ns = S_JAL;
                    default:      ns = S_FETCH;
                endcase
            end
            S_MEMADR:   ns = (o == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  ns = S_MEMWB;
            S_EXECUTER: ns = S_ALUWB;
            S_EXECUTEI: ns = S_ALUWB;
            S_JAL:      ns = S_ALUWB;
            default:    ns = S_FETCH;
        endcase
        return ns;
    endfunction

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ctrl  <= state_ctrl(S_FETCH);
        end else begin
            state <= next_state(state, op);
            ctrl  <= state_ctrl(next_state(state, op));
        end
    end

    // During reset present FETCH selects with every write enable held off.
    always_comb begin
        cur = ctrl;
        if (reset) begin
            cur          = state_ctrl(S_FETCH);
            cur.irwrite  = 1'b0;
            cur.pcupdate = 1'b0;
            cur.regwrite = 1'b0;
            cur.memwrite = 1'b0;
            cur.branch   = 1'b0;
        end
    end

    assign taken = (funct3 == 3'b001) ? ~Zero : Zero;

    assign ImmSrc    = imm_src(op);
    assign ALUSrcA   = cur.alusrca;
    assign ALUSrcB   = cur.alusrcb;
    assign ResultSrc = cur.resultsrc;
    assign AdrSrc    = cur.adrsrc;
    assign IRWrite   = cur.irwrite;
    assign PCWrite   = cur.pcupdate | (cur.branch & taken);
    assign RegWrite  = cur.regwrite;
    assign MemWrite  = cur.memwrite;

    mc_alu_dec u_alu_dec (
        .aluop      (cur.aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction cycle model, randomized instruction stream.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite, PCWrite, RegWrite, MemWrite;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite)
    );

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    // imm, srcA, srcB, resultsrc, adrsrc, alu, ir, pcw, rw, mw
    typedef struct packed {
        logic [1:0] imm, sa, sb, rs;
        logic       adr;
        logic [2:0] alu;
        logic       ir, pcw, rw, mw;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t expv;
    logic chk_en = 1'b0;
    int   pin = 0;

    function automatic int cpi_of(logic [6:0] o);
        case (o)
            LW:      return 5;
            SW, RT, IA, JL: return 4;
            BR:      return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(logic [2:0] f3, logic f7, logic op5);
        logic [2:0] tbl [8];
        tbl = '{3'b000, 3'b110, 3'b101, 3'b000, 3'b100, 3'b111, 3'b011, 3'b010};
        if (f3 == 3'b000 && op5 && f7) return 3'b001;
        return tbl[f3];
    endfunction

    // Expected outputs for cycle k of one instruction (k=0 is its fetch).
    function automatic exp_t model(logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                                   int k, logic rst);
        exp_t e;
        e = '0;
        e.imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        if (rst) begin
            e.sb = 2'b10; e.rs = 2'b10;
            return e;
        end
        if (k == 0) begin
            e.sb = 2'b10; e.rs = 2'b10; e.ir = 1; e.pcw = 1;
        end else if (k == 1) begin
            e.sa = 2'b01; e.sb = 2'b01;
        end else begin
            case (o)
                LW, SW: begin
                    if (k == 2) begin e.sa = 2'b10; e.sb = 2'b01; end
                    else if (k == 3) begin e.adr = 1; e.mw = (o == SW); end
                    else begin e.rs = 2'b01; e.rw = 1; end
                end
                RT: if (k == 2) begin e.sa = 2'b10; e.alu = alu_fn(f3, f7, 1'b1); end
                    else e.rw = 1;
                IA: if (k == 2) begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_fn(f3, f7, 1'b0); end
                    else e.rw = 1;
                BR: begin
                    e.sa = 2'b10; e.alu = 3'b001;
                    e.pcw = (f3 == 3'b001) ? !z : z;
                end
                JL: if (k == 2) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
                    else e.rw = 1;
                default: e = e;
            endcase
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0t op=%b f3=%b got=%h want=%h", name, $time, op, funct3, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctl", {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                        IRWrite, PCWrite, RegWrite, MemWrite}, expv);
            case (pin)
                1: begin
                    chk("post_rst_ir", IRWrite, 1);
                    chk("post_rst_pcw", PCWrite, 1);
                    chk("post_rst_srcb", ALUSrcB, 2'b10);
                end
                2: chk("sub_aluctl", ALUControl, 3'b001);
                3: chk("beq_taken_pcw", PCWrite, 1);
                4: begin
                    chk("sw_memwrite", MemWrite, 1);
                    chk("sw_adrsrc", AdrSrc, 1);
                end
                5: chk("rst_enables", {IRWrite, PCWrite, RegWrite, MemWrite}, 4'b0000);
                6: chk("lw_memwb_rs", {ResultSrc, RegWrite}, 3'b011);
                default: ;
            endcase
        end
    end

    task automatic cyc(logic rst, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                       int k, int p);
        reset = rst; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        expv = model(o, f3, f7, z, k, rst);
        pin = p;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                         int pk, int p, logic rand_z);
        for (int k = 0; k < cpi_of(o); k++)
            cyc(1'b0, o, f3, f7, rand_z ? 1'($urandom_range(0, 1)) : z, k, (k == pk) ? p : 0);
    endtask

    task automatic abort_memadr(logic [6:0] o);
        cyc(1'b0, o, 3'b010, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, o, 3'b010, 1'b0, 1'b0, 1, 0);
        cyc(1'b1, o, 3'b010, 1'b0, 1'b0, 2, 5);
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [6:0] o;
        logic [2:0] f3;
        ops = '{LW, SW, RT, IA, BR, JL, 7'b0110111};
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 0; Zero = 0;
        cyc(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 0, 5);
        cyc(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 0, 5);
        instr(RT, 3'b000, 1'b0, 1'b0, 0, 1, 1'b0);
        instr(RT, 3'b000, 1'b1, 1'b0, 2, 2, 1'b0);
        instr(LW, 3'b010, 1'b0, 1'b0, 4, 6, 1'b0);
        instr(SW, 3'b010, 1'b0, 1'b0, 3, 4, 1'b0);
        instr(BR, 3'b000, 1'b0, 1'b1, 2, 3, 1'b0);
        instr(BR, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        instr(BR, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0);
        instr(BR, 3'b001, 1'b0, 1'b1, 0, 0, 1'b0);
        instr(JL, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        instr(IA, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
        abort_memadr(SW);
        instr(IA, 3'b101, 1'b1, 1'b0, 0, 0, 1'b0);
        abort_memadr(LW);
        for (int n = 0; n < 250; n++) begin
            o  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
            f3 = (o == BR) ? 3'($urandom_range(0, 1)) : 3'($urandom);
            if ((o == LW || o == SW) && $urandom_range(0, 7) == 0)
                abort_memadr(o);
            else
                instr(o, f3, 1'($urandom), 1'b0, 0, 0, 1'b1);
        end
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle RISC-V control unit: a Moore state machine plus combinational ALU and immediate decoders that sequence the shared-memory multicycle datapath. It owns every register-enable, mux select and ALU operation code for the datapath, and the single-ported memory's write strobe. It sits beside the datapath inside the processor wrapper and consumes the fetched instruction fields and the ALU zero flag.

## Interface
Parameters: none.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; state returns to FETCH
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU result == 0
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  out  1  0 PC, 1 Result
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  datapath write enables

## Operation
- Supported instructions: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011 (beq funct3 000, bne funct3 001), jal 1101111.
- Outputs are a function of state only, except three:
  - ImmSrc is decoded from op.
  - ALUControl uses op/funct3/funct7b5 in EXECUTER and EXECUTEI.
  - PCWrite = PCUpdate | (Branch & taken), where taken = Zero for beq and ~Zero for bne.
- Any select or enable that a state does not list below is 0.
- States and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, add, ResultSrc=10, PCUpdate=1. Go to DECODE.
  - DECODE: SrcA=01, SrcB=01, add; ALUOut latches the branch/jump target.
    - lw or sw: go to MEMADR.
    - R-type: go to EXECUTER.
    - I-ALU: go to EXECUTEI.
    - branch: go to BRANCH.
    - jal: go to JAL.
    - anything else: go to FETCH (treated as nop, no writes).
  - MEMADR: SrcA=10, SrcB=01, add. lw goes to MEMREAD; sw goes to MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Go to FETCH.
  - EXECUTER: SrcA=10, SrcB=00, function decode. Go to ALUWB.
  - EXECUTEI: SrcA=10, SrcB=01, function decode. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00, Branch=1. Go to FETCH.
  - JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCUpdate=1. Go to ALUWB, which writes OldPC+4 to rd.
- Function decode from funct3:
  - 000 → add; sub only when op[5]=1 and funct7b5=1.
  - 001 → sll, 010 → slt, 100 → xor, 101 → srl (funct7b5 ignored), 110 → or, 111 → and.
  - 011 → add (unsupported).
- Unused or unknown state encodings recover to FETCH on the next edge.

## Timing
- Reset:
  - With reset high at a rising edge, the next state is FETCH.
  - While reset is high, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
  - The other outputs take their FETCH values.
- The first rising edge with reset low performs FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, I-ALU 4, branch 3, jal 4, unsupported opcode 2.
- MemWrite is high for exactly one cycle per sw and never in any other state.
- RegWrite is high for exactly one cycle per lw, R-type, I-ALU or jal.
- IRWrite is high only in FETCH.
- Zero is sampled combinationally in BRANCH; the PC update happens on that state's closing edge.
- Reset asserted mid-instruction aborts the instruction at the next edge; no partial write enables follow.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum statetype_t;
  - opcode localparams;
  - ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings as named constants, shared with the datapath.
- Natural sub-module: mc_alu_dec (combinational ALUOp[1:0] + funct3/funct7b5/op[5] → ALUControl). The FSM emits ALUOp: 00 add, 01 sub, 10 function decode.
- The FSM and output logic stay in mc_control_unit.

## Test plan
- Reset: hold reset 2 cycles, then release.
  - During reset: all four write enables are 0.
  - First cycle after release: IRWrite=1, PCWrite=1, SrcB=10.
- add, op=0110011 funct3=000 funct7b5=0 → state sequence FETCH, DECODE, EXECUTER (ALUControl=000), ALUWB (RegWrite=1). Repeat with funct7b5=1 → ALUControl=001 in EXECUTER.
- lw, op=0000011 → 5 cycles; MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01 and RegWrite=1; MemWrite stays 0 throughout.
- sw, op=0100011 → ImmSrc=01 in all states; MEMWRITE has MemWrite=1 and AdrSrc=1 for exactly one cycle; back in FETCH on cycle 5.
- beq (funct3=000):
  - Zero=1 → PCWrite=1 in BRANCH.
  - Zero=0 → PCWrite=0.
  - bne (funct3=001) with Zero=0 → PCWrite=1.
  - In all cases ALUControl=001 and ImmSrc=10.
- jal, op=1101111 → JAL state has PCWrite=1, SrcA=01, SrcB=10; ALUWB follows with RegWrite=1. Opcode 0110111 → FETCH after DECODE with no write enables. Reset asserted in MEMADR → FETCH next cycle, MemWrite never asserted.
